// File: rtl/hilo_muldiv_ctrl.sv
// HI/LO multiply/divide unit: single-cycle registered multiply, 32-step restoring divide.
// Latency: done two cycles after acceptance for MULT/MULTU, 33 cycles for DIV/DIVU.
// Backpressure: busy stalls the pipeline from the acceptance cycle until the result cycle.
module hilo_muldiv_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1a;
    localparam logic [5:0] ALU_DIVU  = 6'h1b;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] a_q, b_q;
    logic        sgn_q;
    logic [4:0]  cnt;
    logic [31:0] quo, rem, dvs;

    logic        is_mul, is_div, accept, op_signed;
    logic [31:0] a_mag, b_mag;
    logic [63:0] ext_a, ext_b, prod;
    logic [32:0] r_shift, r_sub;
    logic        ge;
    logic [31:0] quo_nxt, rem_nxt, div_hi, div_lo;

    always_comb begin
        is_mul    = (op == ALU_MULT) || (op == ALU_MULTU);
        is_div    = (op == ALU_DIV)  || (op == ALU_DIVU);
        op_signed = (op == ALU_MULT) || (op == ALU_DIV);
        accept    = (state == IDLE) && start && (is_mul || is_div) && !flush;
        busy      = accept || (state == MUL) || (state == DIV);
        done      = (state == DONE);
        // Divider works on magnitudes; -0x80000000 wraps to 0x80000000 which is the correct unsigned magnitude
        a_mag     = (op_signed && a[31]) ? -a : a;
        b_mag     = (op_signed && b[31]) ? -b : b;
    end

    always_comb begin
        ext_a = {{32{sgn_q & a_q[31]}}, a_q};
        ext_b = {{32{sgn_q & b_q[31]}}, b_q};
        prod  = ext_a * ext_b;
    end

    always_comb begin
        r_shift = {rem, quo[31]};
        r_sub   = r_shift - {1'b0, dvs};
        ge      = (r_shift >= {1'b0, dvs});
        rem_nxt = ge ? r_sub[31:0] : r_shift[31:0];
        quo_nxt = {quo[30:0], ge};
        if (dvs == 32'd0) begin
            // Divide by zero: raw dividend in HI, all-ones quotient, no sign fix-up
            div_lo = 32'hffff_ffff;
            div_hi = a_q;
        end else begin
            div_lo = (sgn_q && (a_q[31] ^ b_q[31])) ? -quo_nxt : quo_nxt;
            div_hi = (sgn_q && a_q[31]) ? -rem_nxt : rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = is_mul ? MUL : DIV;
            MUL:  state_nxt = DONE;
            DIV:  if (cnt == 5'd31) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (flush) state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 5'd0;
            a_q   <= 32'd0;
            b_q   <= 32'd0;
            sgn_q <= 1'b0;
            quo   <= 32'd0;
            rem   <= 32'd0;
            dvs   <= 32'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                a_q   <= a;
                b_q   <= b;
                sgn_q <= op_signed;
                quo   <= a_mag;
                dvs   <= b_mag;
                rem   <= 32'd0;
                cnt   <= 5'd0;
            end else if (state == DIV && !flush) begin
                quo <= quo_nxt;
                rem <= rem_nxt;
                cnt <= cnt + 5'd1;
            end
            // state_nxt is already IDLE under flush, so a flushed op never reaches here
            if (state_nxt == DONE && state != DONE) begin
                if (state == MUL) begin
                    hi <= prod[63:32];
                    lo <= prod[31:0];
                end else begin
                    hi <= div_hi;
                    lo <= div_lo;
                end
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Directed bench for hilo_muldiv_ctrl: latency, results, flush and reset behaviour.
module tb_hilo_muldiv_ctrl;

    localparam logic [5:0] ALU_MULT  = 6'h18;
    localparam logic [5:0] ALU_MULTU = 6'h19;
    localparam logic [5:0] ALU_DIV   = 6'h1a;
    localparam logic [5:0] ALU_DIVU  = 6'h1b;
    localparam logic [5:0] ALU_ADD   = 6'h20;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [5:0]  op;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] hi, lo;

    int errs   = 0;
    int checks = 0;

    hilo_muldiv_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Issue one op in the current cycle and follow it to its result; optionally keep
    // start asserted with a different op while busy to confirm it is ignored.
    task automatic run_op(input string tag, input logic [5:0] o, input logic [31:0] ia,
                          input logic [31:0] ib, input int lat, input logic [31:0] eh,
                          input logic [31:0] el, input bit hold);
        int bad;
        start = 1'b1; op = o; a = ia; b = ib;
        @(negedge clk);
        chk({tag, "_acc_busy"}, busy, 1);
        next();
        if (hold) begin
            op = ALU_MULTU; a = ~ia; b = 32'd5;
        end else begin
            start = 1'b0;
        end
        bad = 0;
        for (int i = 1; i < lat; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0) bad++;
            next();
        end
        // Start during DONE must be ignored
        start = 1'b1; op = ALU_MULT;
        @(negedge clk);
        chk({tag, "_stall_window"}, bad, 0);
        chk({tag, "_done"}, done, 1);
        chk({tag, "_busy_done"}, busy, 0);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        next();
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_after_busy"}, busy, 0);
        chk({tag, "_after_done"}, done, 0);
        chk({tag, "_hold_lo"}, lo, el);
        next();
    endtask

    initial begin
        int bad;
        rst = 1'b1; start = 1'b0; flush = 1'b0; op = 6'd0; a = 32'd0; b = 32'd0;
        next();
        next();
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        next();
        rst = 1'b0;
        next();

        run_op("mult_neg", ALU_MULT,  32'hffff_fffe, 32'd3,         2,  32'hffff_ffff, 32'hffff_fffa, 1'b0);
        run_op("multu_max", ALU_MULTU, 32'hffff_ffff, 32'hffff_ffff, 2,  32'hffff_fffe, 32'h0000_0001, 1'b0);
        run_op("mult_m1",  ALU_MULT,  32'hffff_ffff, 32'hffff_ffff, 2,  32'h0000_0000, 32'h0000_0001, 1'b0);
        run_op("divu",     ALU_DIVU,  32'd100,       32'd7,         33, 32'd2,         32'd14,        1'b1);
        run_op("div_neg",  ALU_DIV,   32'hffff_fff9, 32'd2,         33, 32'hffff_ffff, 32'hffff_fffd, 1'b0);
        run_op("div_negb", ALU_DIV,   32'd7,         32'hffff_fffe, 33, 32'd1,         32'hffff_fffd, 1'b0);
        run_op("div_wrap", ALU_DIV,   32'h8000_0000, 32'hffff_ffff, 33, 32'd0,         32'h8000_0000, 1'b0);
        run_op("divu_z",   ALU_DIVU,  32'h1234_5678, 32'd0,         33, 32'h1234_5678, 32'hffff_ffff, 1'b0);
        run_op("div_z",    ALU_DIV,   32'hffff_fff9, 32'd0,         33, 32'hffff_fff9, 32'hffff_ffff, 1'b0);

        // Flush mid-divide
        start = 1'b1; op = ALU_DIV; a = 32'd1000; b = 32'd3;
        @(negedge clk);
        chk("fl_acc_busy", busy, 1);
        next();
        start = 1'b0;
        repeat (9) next();
        flush = 1'b1;
        @(negedge clk);
        chk("fl_busy_in_div", busy, 1);
        next();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_idle_busy", busy, 0);
        chk("fl_idle_done", done, 0);
        start = 1'b1; op = ALU_DIVU; flush = 1'b1;
        #1;
        chk("fl_idle_start_busy", busy, 0);
        next();
        start = 1'b0; flush = 1'b0;
        @(negedge clk);
        chk("fl_not_accepted", busy, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
            next();
        end
        chk("fl_no_done", bad, 0);
        chk("fl_hi_kept", hi, 32'hffff_fff9);
        chk("fl_lo_kept", lo, 32'hffff_ffff);
        run_op("multu_5x6", ALU_MULTU, 32'd5, 32'd6, 2, 32'd0, 32'd30, 1'b0);

        // Reset mid-divide
        start = 1'b1; op = ALU_DIV; a = 32'hffff_fff9; b = 32'd2;
        next();
        start = 1'b0;
        repeat (4) next();
        rst = 1'b1;
        next();
        rst = 1'b0;
        @(negedge clk);
        chk("rd_busy", busy, 0);
        chk("rd_done", done, 0);
        chk("rd_hi", hi, 0);
        chk("rd_lo", lo, 0);
        next();
        start = 1'b1; op = ALU_ADD; a = 32'd1; b = 32'd2;
        @(negedge clk);
        chk("add_busy", busy, 0);
        next();
        start = 1'b0;
        @(negedge clk);
        chk("add_no_state", busy, 0);
        bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (done !== 1'b0) bad++;
            next();
        end
        chk("rd_no_done", bad, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
